// File: rtl/voice_mix_scheduler.sv
// Voice mix scheduler: polls synth voices once per audio frame, sums their samples with
// saturation and presents the mix to the I2S transmitter at a fixed frame phase.
`timescale 1ns/1ps
module voice_mix_scheduler #(
    parameter int NUM_VOICES   = 4,
    parameter int FRAME_CYCLES = 1024,
    parameter int UPDATE_PHASE = 512,
    parameter int TIMEOUT      = 64
) (
    input  logic                     clk48m,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_VOICES-1:0]    voice_mask,
    input  logic [16*NUM_VOICES-1:0] voice_data,
    input  logic [NUM_VOICES-1:0]    ack,
    input  logic                     clear_flags,
    output logic [NUM_VOICES-1:0]    req,
    output logic [15:0]              sample_out,
    output logic                     frame_tick,
    output logic                     busy,
    output logic [NUM_VOICES-1:0]    miss,
    output logic                     overrun
);
    // state | meaning
    // IDLE  | waiting for frame phase 0; also parked when muted or finished
    // SCAN  | evaluate voice idx: skip if masked, otherwise raise req[idx]
    // WAIT  | req[idx] held high until ack or timeout
    // DONE  | saturate accumulator into the pending sample
    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    localparam int PH_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_VOICES + 1);
    localparam int WT_W  = $clog2(TIMEOUT + 1);
    localparam int ACC_W = 16 + $clog2(NUM_VOICES) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WT_W-1:0]         wait_q, wait_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             pending_q, pending_d;
    logic [15:0]             sample_out_q, sample_out_d;
    logic [NUM_VOICES-1:0]   req_q, req_d;
    logic [NUM_VOICES-1:0]   miss_q, miss_d;
    logic                    overrun_q, overrun_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    muted_q, muted_d;
    logic                    done_q, done_d;

    logic                    cur_mask, cur_ack;
    logic signed [15:0]      cur_data;
    logic [NUM_VOICES-1:0]   cur_onehot;

    always_comb begin
        cur_mask   = 1'b0;
        cur_ack    = 1'b0;
        cur_data   = '0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_mask      = voice_mask[i];
                cur_ack       = ack[i];
                cur_data      = voice_data[16*i +: 16];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = (phase_q == PH_W'(FRAME_CYCLES - 1)) ? '0 : phase_q + PH_W'(1);
        idx_d        = idx_q;
        wait_d       = wait_q;
        acc_d        = acc_q;
        pending_d    = pending_q;
        sample_out_d = sample_out_q;
        req_d        = req_q;
        miss_d       = miss_q;
        overrun_d    = overrun_q;
        frame_tick_d = (phase_q == '0);
        muted_d      = muted_q;
        done_d       = done_q;

        // Clear first so that a set in the same cycle wins.
        if (clear_flags) begin
            miss_d    = '0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (phase_q == '0) begin
                    done_d = 1'b0;
                    if (enable) begin
                        acc_d   = '0;
                        idx_d   = '0;
                        muted_d = 1'b0;
                        state_d = SCAN;
                    end else begin
                        muted_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (idx_q == IDX_W'(NUM_VOICES)) begin
                    state_d = DONE;
                end else if (!cur_mask) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    req_d   = cur_onehot;
                    wait_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cur_ack) begin
                    acc_d   = acc_q + ACC_W'(cur_data);
                    req_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SCAN;
                end else if (wait_q == WT_W'(TIMEOUT - 1)) begin
                    req_d   = '0;
                    miss_d  = miss_d | cur_onehot;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SCAN;
                end else begin
                    wait_d = wait_q + WT_W'(1);
                end
            end
            DONE: begin
                if (acc_q > SAT_MAX)      pending_d = 16'h7fff;
                else if (acc_q < SAT_MIN) pending_d = 16'h8000;
                else                      pending_d = acc_q[15:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A sequence still running at the update point is abandoned, not waited for.
        if (phase_q == PH_W'(UPDATE_PHASE)) begin
            if (muted_q) begin
                sample_out_d = '0;
            end else if (state_q != IDLE) begin
                overrun_d = 1'b1;
                req_d     = '0;
                acc_d     = '0;
                state_d   = IDLE;
            end else if (done_q) begin
                sample_out_d = pending_q;
            end
        end
    end

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            acc_q        <= '0;
            pending_q    <= '0;
            sample_out_q <= '0;
            req_q        <= '0;
            miss_q       <= '0;
            overrun_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            muted_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            acc_q        <= acc_d;
            pending_q    <= pending_d;
            sample_out_q <= sample_out_d;
            req_q        <= req_d;
            miss_q       <= miss_d;
            overrun_q    <= overrun_d;
            frame_tick_q <= frame_tick_d;
            muted_q      <= muted_d;
            done_q       <= done_d;
        end
    end

    assign req        = req_q;
    assign sample_out = sample_out_q;
    assign frame_tick = frame_tick_q;
    assign busy       = (state_q != IDLE);
    assign miss       = miss_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Bench for voice_mix_scheduler: directed and random frames checked against a per-frame
// behavioural model (sum of acked voices, saturated); a second instance with a long timeout.
`timescale 1ns/1ps
module tb_voice_mix_scheduler;
    localparam int NV    = 4;
    localparam int FRAME = 1024;
    localparam int UPD   = 512;
    localparam int TMO   = 64;
    localparam int TMO2  = 200;

    logic            clk48m = 1'b0;
    logic            rst;
    logic            enable;
    logic [NV-1:0]   voice_mask;
    logic [16*NV-1:0] voice_data;
    logic [NV-1:0]   ack, ack2;
    logic            clear_flags;
    logic [NV-1:0]   req, req2, miss, miss2;
    logic [15:0]     sample_out, sample_out2;
    logic            frame_tick, frame_tick2, busy, busy2, overrun, overrun2;
    logic [NV-1:0]   resp_mask;

    int checks = 0;
    int failures = 0;
    int req_cnt [NV];
    int onehot_viol, ord_code, since_tick, tick_period;
    logic [NV-1:0] req_prev;
    logic [15:0]   prev_exp;

    always #10 clk48m = ~clk48m;

    voice_mix_scheduler #(.NUM_VOICES(NV), .FRAME_CYCLES(FRAME), .UPDATE_PHASE(UPD), .TIMEOUT(TMO)) dut (
        .clk48m(clk48m), .rst(rst), .enable(enable), .voice_mask(voice_mask),
        .voice_data(voice_data), .ack(ack), .clear_flags(clear_flags), .req(req),
        .sample_out(sample_out), .frame_tick(frame_tick), .busy(busy), .miss(miss),
        .overrun(overrun));

    voice_mix_scheduler #(.NUM_VOICES(NV), .FRAME_CYCLES(FRAME), .UPDATE_PHASE(UPD), .TIMEOUT(TMO2)) dut_to (
        .clk48m(clk48m), .rst(rst), .enable(enable), .voice_mask(voice_mask),
        .voice_data(voice_data), .ack(ack2), .clear_flags(clear_flags), .req(req2),
        .sample_out(sample_out2), .frame_tick(frame_tick2), .busy(busy2), .miss(miss2),
        .overrun(overrun2));

    // Voice responders: answer one cycle after req if the voice is set to respond.
    initial begin
        ack  = '0;
        ack2 = '0;
        forever begin
            @(negedge clk48m);
            ack  = req & resp_mask;
            ack2 = req2 & resp_mask;
        end
    end

    // Per-frame observation of req: high-cycle counts, one-hot violations, rising order.
    initial begin
        since_tick = 0; tick_period = 0; ord_code = 0; onehot_viol = 0; req_prev = '0;
        for (int i = 0; i < NV; i++) req_cnt[i] = 0;
        forever begin
            @(negedge clk48m);
            if (frame_tick) begin
                tick_period = since_tick;
                since_tick  = 0;
                ord_code    = 0;
                onehot_viol = 0;
                for (int i = 0; i < NV; i++) req_cnt[i] = 0;
            end
            since_tick++;
            if ((req & (req - 1'b1)) != '0) onehot_viol++;
            for (int i = 0; i < NV; i++) begin
                if (req[i]) req_cnt[i]++;
                if (req[i] && !req_prev[i]) ord_code = (ord_code << 4) | (i + 1);
            end
            req_prev = req;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk48m);
        while (!frame_tick && n < 2 * FRAME) begin
            @(negedge clk48m);
            n++;
        end
        check("tick_seen", 32'(frame_tick), 32'd1);
    endtask

    task automatic goto_safe();
        wait_tick();
        repeat (UPD) @(negedge clk48m);
    endtask

    // Configure at phase 513, run one full frame, check at phases 512 and 513.
    task automatic run_frame(input string tag, input logic [16*NV-1:0] d, input logic [NV-1:0] m,
                             input logic [NV-1:0] r, input logic en);
        int sum;
        int exp_ord;
        int exp_cnt;
        logic signed [15:0] s;
        logic [15:0] exp_s;
        logic [NV-1:0] exp_miss;
        voice_data = d; voice_mask = m; resp_mask = r; enable = en;
        clear_flags = 1'b1;
        @(negedge clk48m);
        clear_flags = 1'b0;
        sum = 0; exp_ord = 0; exp_miss = '0;
        for (int i = 0; i < NV; i++) begin
            if (en && m[i]) begin
                exp_ord = (exp_ord << 4) | (i + 1);
                if (r[i]) begin
                    s = d[16*i +: 16];
                    sum += int'(s);
                end else begin
                    exp_miss[i] = 1'b1;
                end
            end
        end
        if (sum > 32767) sum = 32767;
        else if (sum < -32768) sum = -32768;
        exp_s = 16'(sum);
        wait_tick();
        repeat (UPD - 1) @(negedge clk48m);
        check({tag, "_hold512"}, 32'(sample_out), 32'(prev_exp));
        @(negedge clk48m);
        check({tag, "_sample"}, 32'(sample_out), 32'(exp_s));
        check({tag, "_miss"}, 32'(miss), 32'(exp_miss));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_order"}, 32'(ord_code), 32'(exp_ord));
        check({tag, "_onehot"}, 32'(onehot_viol), 32'd0);
        for (int i = 0; i < NV; i++) begin
            exp_cnt = (en && m[i]) ? (r[i] ? 1 : TMO) : 0;
            check($sformatf("%s_reqcnt%0d", tag, i), 32'(req_cnt[i]), 32'(exp_cnt));
        end
        prev_exp = exp_s;
    endtask

    initial begin
        logic [15:0] a_val;
        rst = 1'b1; enable = 1'b0; voice_mask = '0; voice_data = '0;
        clear_flags = 1'b0; resp_mask = '0; prev_exp = '0;
        repeat (3) @(negedge clk48m);
        check("rst_req", 32'(req), 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;
        goto_safe();

        run_frame("basic", {16'sd0, -16'sd500, 16'sd2000, 16'sd1000}, 4'b1111, 4'b1111, 1'b1);
        run_frame("sat_hi", {4{16'sd20000}}, 4'b1111, 4'b1111, 1'b1);
        run_frame("sat_lo", {4{-16'sd20000}}, 4'b1111, 4'b1111, 1'b1);
        run_frame("masked", {16'sd400, 16'sd300, 16'sd200, 16'sd100}, 4'b0101, 4'b1111, 1'b1);
        run_frame("timeout", {16'sd40, 16'sd30, 16'sd999, 16'sd10}, 4'b1111, 4'b1101, 1'b1);
        clear_flags = 1'b1;
        @(negedge clk48m);
        clear_flags = 1'b0;
        check("clear_miss", 32'(miss), 32'd0);

        for (int f = 0; f < 6; f++) begin
            run_frame($sformatf("rand%0d", f), {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'b1);
        end

        // Long-timeout instance: normal frame, overrun frame, recovery frame.
        run_frame("pre_ovr", {16'sd700, 16'sd600, 16'sd500, 16'sd400}, 4'b1111, 4'b1111, 1'b1);
        check("to_pre_sample", 32'(sample_out2), 32'(prev_exp));
        a_val = prev_exp;
        run_frame("no_ack", {4{16'sd1111}}, 4'b1111, 4'b0000, 1'b1);
        check("to_overrun", 32'(overrun2), 32'd1);
        check("to_sample_kept", 32'(sample_out2), 32'(a_val));
        check("to_req_zero", 32'(req2), 32'd0);
        check("to_busy_zero", 32'(busy2), 32'd0);
        repeat (5) @(negedge clk48m);
        check("to_req_zero_later", 32'(req2), 32'd0);
        run_frame("post_ovr", {-16'sd1200, 16'sd300, 16'sd50, 16'sd7}, 4'b1111, 4'b1111, 1'b1);
        check("to_post_sample", 32'(sample_out2), 32'(prev_exp));
        check("to_post_overrun_clr", 32'(overrun2), 32'd0);

        // Asynchronous reset while voice 0 is waiting for ack.
        voice_mask = 4'b1111; resp_mask = 4'b0000; enable = 1'b1;
        wait_tick();
        repeat (10) @(negedge clk48m);
        check("pre_rst_req", 32'(req), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_sample", 32'(sample_out), 32'(prev_exp));
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", 32'(req), 32'd0);
        check("async_rst_sample", 32'(sample_out), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk48m);
        rst = 1'b0;
        prev_exp = '0;
        goto_safe();
        check("post_rst_sample", 32'(sample_out), 32'd0);
        check("post_rst_miss", 32'(miss), 32'hf);

        run_frame("post_rst", {$urandom, $urandom}, 4'b1111, 4'b1111, 1'b1);
        run_frame("mute", {4{16'sd1234}}, 4'b1111, 4'b1111, 1'b0);
        check("mute_tick_period", 32'(tick_period), 32'(FRAME));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
